// File: rtl/obuf_pack4x1.sv
// obuf_pack4x1: collects serial accumulator results from one array column, requantizes each
// to a byte and packs four bytes (first arrival in [31:24]) into a 32-bit word. Completed
// words are handed downstream through a valid/ready holding register.
// Optional build macro OBUF_SATURATE_EN selects signed saturation instead of truncation.
module obuf_pack4x1 #(
  parameter int unsigned ACC_W = 20,
  parameter int unsigned SHIFT = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [ACC_W-1:0] IData,
  input  logic             FLUSH,
  input  logic             ORdy,
  output logic [31:0]      OWord,
  output logic             OValid,
  output logic             Busy,
  output logic             Ovf,
  output logic [15:0]      WCnt
);

  logic [7:0]  in_byte;
  logic [31:0] pk_q, pk_d, merged;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  fill;
  logic        done;
  logic [31:0] oword_q, oword_d;
  logic        ovalid_q, ovalid_d;
  logic        busy_q;
  logic        ovf_q, ovf_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        hs;

`ifdef OBUF_SATURATE_EN
  localparam logic signed [ACC_W-1:0] MaxV = 127;
  localparam logic signed [ACC_W-1:0] MinV = -128;
  logic signed [ACC_W-1:0] shifted;
  logic                    unused_shifted;

  assign shifted = $signed(IData) >>> SHIFT;
  // Only the comparisons look at the upper bits of the shifted value.
  assign unused_shifted = 1'b0;

  // Clamp the shifted accumulator into the signed 8-bit range.
  always_comb begin
    in_byte = shifted[7:0];
    if (shifted > MaxV) begin
      in_byte = 8'h7F;
    end else if (shifted < MinV) begin
      in_byte = 8'h80;
    end
  end
`else
  logic unused_idata;

  assign in_byte      = IData[SHIFT+7:SHIFT];
  // Bits outside the selected byte are deliberately discarded.
  assign unused_idata = ^IData;
`endif

  assign hs = ovalid_q & ORdy;

  // Pack the incoming byte into its slot and decide whether a word completes this cycle.
  always_comb begin
    merged = pk_q;
    if (EN) begin
      unique case (cnt_q)
        2'd0:    merged[31:24] = in_byte;
        2'd1:    merged[23:16] = in_byte;
        2'd2:    merged[15:8]  = in_byte;
        default: merged[7:0]   = in_byte;
      endcase
    end
    fill = {1'b0, cnt_q} + {2'b00, EN};
    // A flush after the packing step emits whatever is held; the full case covers itself.
    done = (fill == 3'd4) || (FLUSH && (fill != 3'd0));
    if (done) begin
      // Clearing here keeps unfilled low slots zero for the next partial flush.
      pk_d  = '0;
      cnt_d = 2'd0;
    end else begin
      pk_d  = merged;
      cnt_d = fill[1:0];
    end
  end

  // Holding register, overflow and accepted-word counter next state.
  always_comb begin
    oword_d  = oword_q;
    ovalid_d = ovalid_q;
    ovf_d    = ovf_q;
    wcnt_d   = wcnt_q;
    if (hs) begin
      wcnt_d = wcnt_q + 16'd1;
    end
    if (done) begin
      if (!ovalid_q || ORdy) begin
        oword_d  = merged;
        ovalid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (hs) begin
      ovalid_d = 1'b0;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pk_q     <= '0;
      cnt_q    <= 2'd0;
      oword_q  <= '0;
      ovalid_q <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      pk_q     <= pk_d;
      cnt_q    <= cnt_d;
      oword_q  <= oword_d;
      ovalid_q <= ovalid_d;
      busy_q   <= (cnt_d != 2'd0);
      ovf_q    <= ovf_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign OWord  = oword_q;
  assign OValid = ovalid_q;
  assign Busy   = busy_q;
  assign Ovf    = ovf_q;
  assign WCnt   = wcnt_q;

endmodule

// File: tb/tb_obuf_pack4x1.sv
// Randomized and directed bench for obuf_pack4x1 against a byte-queue reference model.
module tb_obuf_pack4x1;
  localparam int unsigned ACC_W = 20;
  localparam int unsigned SHIFT = 0;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             EN = 1'b0;
  logic [ACC_W-1:0] IData = '0;
  logic             FLUSH = 1'b0;
  logic             ORdy = 1'b0;
  logic [31:0]      OWord;
  logic             OValid;
  logic             Busy;
  logic             Ovf;
  logic [15:0]      WCnt;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state
  logic [7:0]  m_bytes[$];
  logic [31:0] m_word;
  logic        m_valid;
  logic        m_ovf;
  int          m_wcnt;

  obuf_pack4x1 #(.ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .IData(IData), .FLUSH(FLUSH), .ORdy(ORdy),
    .OWord(OWord), .OValid(OValid), .Busy(Busy), .Ovf(Ovf), .WCnt(WCnt)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] conv(input logic [ACC_W-1:0] d);
    int v;
    v = $signed(d);
    v = v >>> SHIFT;
`ifdef OBUF_SATURATE_EN
    if (v > 127) return 8'h7F;
    if (v < -128) return 8'h80;
`endif
    return v[7:0];
  endfunction

  task automatic model_step(input logic en, input logic [ACC_W-1:0] d, input logic fl,
                            input logic rdy, input logic rst);
    logic        hs;
    logic        fin;
    logic [31:0] w;
    if (rst) begin
      m_bytes.delete();
      m_word  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_wcnt  = 0;
      return;
    end
    hs  = m_valid && rdy;
    fin = 1'b0;
    w   = '0;
    if (en) m_bytes.push_back(conv(d));
    if (m_bytes.size() == 4 || (fl && m_bytes.size() > 0)) begin
      for (int i = 0; i < m_bytes.size(); i++) w = w | ({24'h0, m_bytes[i]} << (24 - 8 * i));
      m_bytes.delete();
      fin = 1'b1;
    end
    if (hs) m_wcnt = (m_wcnt + 1) % 65536;
    if (fin) begin
      if (!m_valid || rdy) begin
        m_word  = w;
        m_valid = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (hs) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    check_eq("OValid", {31'h0, OValid}, {31'h0, m_valid});
    if (m_valid) check_eq("OWord", OWord, m_word);
    check_eq("Busy", {31'h0, Busy}, {31'h0, (m_bytes.size() != 0)});
    check_eq("Ovf", {31'h0, Ovf}, {31'h0, m_ovf});
    check_eq("WCnt", {16'h0, WCnt}, m_wcnt[31:0]);
  endtask

  task automatic step(input logic en, input logic [ACC_W-1:0] d, input logic fl,
                      input logic rdy, input logic rst);
    EN    = en;
    IData = d;
    FLUSH = fl;
    ORdy  = rdy;
    RST   = rst;
    model_step(en, d, fl, rdy, rst);
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_eq("reset_oword", OWord, 32'h0);
  endtask

  initial begin
    logic [ACC_W-1:0] d;
    logic [7:0]       b;

    // 1: basic pack with ready high
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, ACC_W'(i), 1'b0, 1'b1, 1'b0);
    check_eq("t1_word", OWord, 32'h01020304);
    check_eq("t1_valid", {31'h0, OValid}, 32'h1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_eq("t1_valid_drop", {31'h0, OValid}, 32'h0);
    check_eq("t1_wcnt", {16'h0, WCnt}, 32'h1);

    // 2: overflow while stalled
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, ACC_W'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    check_eq("t2_word", OWord, 32'h10111213);
    check_eq("t2_ovf", {31'h0, Ovf}, 32'h1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_eq("t2_wcnt", {16'h0, WCnt}, 32'h1);

    // 3: completion coincides with handshake
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, ACC_W'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, ACC_W'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, ACC_W'(8'hB3), 1'b0, 1'b1, 1'b0);
    check_eq("t3_word2", OWord, 32'hB0B1B2B3);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_eq("t3_wcnt", {16'h0, WCnt}, 32'h2);
    check_eq("t3_ovf", {31'h0, Ovf}, 32'h0);

    // 4: partial flush, then empty flush
    do_reset();
    step(1'b1, ACC_W'(8'h11), 1'b0, 1'b1, 1'b0);
    step(1'b1, ACC_W'(8'h22), 1'b0, 1'b1, 1'b0);
    step(1'b1, ACC_W'(8'h33), 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check_eq("t4_word", OWord, 32'h11223300);
    check_eq("t4_busy", {31'h0, Busy}, 32'h0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check_eq("t4_noflush", {31'h0, OValid}, 32'h0);

    // 5: requantization of out-of-range values
    do_reset();
    step(1'b1, ACC_W'(300), 1'b0, 1'b1, 1'b0);
    step(1'b1, ACC_W'(-300), 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
`ifdef OBUF_SATURATE_EN
    check_eq("t5_sat", OWord, 32'h7F800000);
`else
    check_eq("t5_trunc", OWord, 32'h2CD40000);
`endif

    // 6: reset mid-fill while holding a word
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, ACC_W'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    do_reset();
    check_eq("t6_valid", {31'h0, OValid}, 32'h0);
    check_eq("t6_busy", {31'h0, Busy}, 32'h0);
    for (int i = 1; i <= 4; i++) step(1'b1, ACC_W'(i), 1'b0, 1'b1, 1'b0);
    check_eq("t6_word", OWord, 32'h01020304);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom);
        d = ACC_W'($signed(b)) * ACC_W'($urandom_range(1, 4));
      end else begin
        d = ACC_W'($urandom);
      end
      step($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 149) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
